dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Load/store unit that sits between the CPU execute stage and `data_memory`, acting as the initiator on the memory's addr/data/we/q interface. It accepts one byte-addressed load or store per valid/ready handshake and converts it to word-addressed memory accesses. Byte stores are done as read-modify-write, because the memory is word-wide. Load data is byte-lane selected, sign- or zero-extended, and returned on a valid/ready response channel.

## Interface
- `DATA_WIDTH`, 16, memory word and CPU data width.
- `ADDR_WIDTH`, 16, CPU byte address and memory address width.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 1: 0 = byte, 1 = word.
- `req_unsigned` in 1: byte load zero-extends when 1, sign-extends when 0.
- `req_addr` in ADDR_WIDTH: byte address; little-endian (addr[0]=0 selects bits 7:0).
- `req_wdata` in DATA_WIDTH: store data; byte stores use bits 7:0.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: CPU takes response.
- `resp_rdata` out DATA_WIDTH: load result; 0 for stores and errors.
- `resp_err` out 1: misaligned word access.
- `mem_addr` out ADDR_WIDTH: word address = {1'b0, addr[15:1]}.
- `mem_data` out DATA_WIDTH: write data to memory.
- `mem_we` out 1: memory write enable.
- `mem_q` in DATA_WIDTH: combinational read data for `mem_addr`.

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE → on `req_valid && req_ready`, latch all request fields.
  - Misaligned word access (size=1, addr[0]=1) → RESP with err=1. No memory cycle is issued.
  - Load → LOAD.
  - Word store → WRITE.
  - Byte store → RMW_READ.
- LOAD: drive `mem_addr` and capture `mem_q` at the clock edge.
  - Word load: result is the full word.
  - Byte load: select the addressed lane and extend it to 16 bits.
  - Next state → RESP.
- RMW_READ: capture `mem_q` and merge `req_wdata[7:0]` into the addressed lane; the other lane is preserved. Next state → WRITE.
- WRITE: `mem_we`=1 for exactly this one cycle, with `mem_data` = the word or the merged word. Next state → RESP.
- RESP: `resp_valid`=1, and `resp_rdata`/`resp_err` are held stable until `resp_ready`. Then → IDLE.
- One transaction outstanding at a time. `req_ready`=0 in every state except IDLE.
- `mem_we` is 0 in all states except WRITE. `mem_addr` holds the latched word address from acceptance until the next acceptance.

## Timing
- Acceptance edge = cycle 0.
- Word load: LOAD in cycle 1, `resp_valid` in cycle 2.
- Word store: write in cycle 1, `resp_valid` in cycle 2.
- Byte load: `resp_valid` in cycle 2.
- Byte store: read in cycle 1, write in cycle 2, `resp_valid` in cycle 3.
- Error: `resp_valid` in cycle 1.
- If `resp_ready` is high in the first RESP cycle, IDLE is reached the next cycle. Back-to-back throughput: one word access per 3 cycles.
- Reset (asynchronous, any state): state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `mem_we`=0, `mem_addr`=0, `mem_data`=0.
  - A write in flight is abandoned and the request is lost.
  - An RMW aborted between read and write leaves memory unmodified.
- `req_valid` outside IDLE is ignored; the CPU holds the request until `req_ready`.

## Configuration
- `DMEM_LSU_MISALIGN_TRAP_EN` defined: misaligned word accesses are rejected with `resp_err`=1 and no memory access.
- Undefined: `resp_err` is tied 0. Word accesses ignore addr[0] and use word address addr[15:1], so they are forced aligned.

## Structure
- Package `dmem_lsu_pkg` holds:
  - The state enum.
  - Size encodings SIZE_BYTE=0 and SIZE_WORD=1.
  - The width constant for the byte lane (8).
- Sub-module `lsu_byte_lane` (combinational) provides:
  - Lane extract with sign/zero extension.
  - Lane merge for RMW.
- The FSM and registers stay in `dmem_lsu`.

## Test plan
- Word store of 0xBEEF to addr 0x0010, then word load from 0x0010 → mem write at word 0x0008; load returns 0xBEEF, err=0.
- Memory word 0x0008 holds 0x80F1:
  - Byte load unsigned from addr 0x0011 → 0x0080.
  - Byte load signed from addr 0x0011 → 0xFF80.
  - Byte load signed from addr 0x0010 → 0xFFF1.
- Memory word 0x0008 holds 0x1234. Byte store of 0xAB to addr 0x0011 → write cycle is exactly 2 cycles after acceptance; word becomes 0xAB34. Byte store of 0xCD to 0x0010 → word becomes 0xABCD.
- Word load from 0x0013 with the macro defined → `resp_valid` one cycle after acceptance, err=1, rdata=0, `mem_we` never asserted. Without the macro → returns word 0x0009, err=0.
- Hold `resp_ready`=0 for 5 cycles in RESP → `resp_valid` and `resp_rdata` stable, `req_ready`=0; a new `req_valid` is not accepted until one cycle after `resp_ready`.
- Assert `rst` low during the RMW_READ cycle of a byte store to a word holding 0x5555 → outputs take their reset values immediately, the word stays 0x5555, and the next request completes normally.

Source files
------------

// File: rtl/dmem_lsu_pkg.sv
// Shared types and constants for the dmem_lsu load/store unit.
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;
  localparam int   LANE_W    = 8;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: extracts/extends a load lane and merges a store byte
// into a word for read-modify-write.
module lsu_byte_lane import dmem_lsu_pkg::*; #(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] word_i,
  input  logic                  lane_sel_i,
  input  logic                  unsigned_i,
  input  logic [LANE_W-1:0]     byte_i,
  output logic [DATA_WIDTH-1:0] ext_o,
  output logic [DATA_WIDTH-1:0] merged_o
);

  logic [LANE_W-1:0] lane;

  always_comb begin
    lane     = lane_sel_i ? word_i[2*LANE_W-1:LANE_W] : word_i[LANE_W-1:0];
    ext_o    = {{(DATA_WIDTH-LANE_W){~unsigned_i & lane[LANE_W-1]}}, lane};
    merged_o = word_i;
    if (lane_sel_i) merged_o[2*LANE_W-1:LANE_W] = byte_i;
    else            merged_o[LANE_W-1:0]        = byte_i;
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit: byte-addressed CPU requests to a word-wide memory.
// Define DMEM_LSU_MISALIGN_TRAP_EN to reject misaligned word accesses.
module dmem_lsu import dmem_lsu_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q
);

  state_e                state_q, state_d;
  logic                  lane_q, lane_d;
  logic                  size_q, size_d;
  logic                  uns_q, uns_d;
  logic [LANE_W-1:0]     wbyte_q, wbyte_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  misalign;
  logic [DATA_WIDTH-1:0] lane_ext, lane_merged;

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == SIZE_WORD) && req_addr[0];
`else
  // Word accesses drop addr[0] through the word address, so they are always aligned.
  assign misalign = 1'b0;
`endif

  lsu_byte_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .word_i     (mem_q),
    .lane_sel_i (lane_q),
    .unsigned_i (uns_q),
    .byte_i     (wbyte_q),
    .ext_o      (lane_ext),
    .merged_o   (lane_merged)
  );

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wbyte_d    = wbyte_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        lane_d     = req_addr[0];
        size_d     = req_size;
        uns_d      = req_unsigned;
        wbyte_d    = req_wdata[LANE_W-1:0];
        mem_addr_d = {1'b0, req_addr[ADDR_WIDTH-1:1]};
        rdata_d    = '0;
        err_d      = misalign;
        if (req_we && req_size == SIZE_WORD) mem_data_d = req_wdata;
        if (misalign)                   state_d = S_RESP;
        else if (!req_we)               state_d = S_LOAD;
        else if (req_size == SIZE_WORD) state_d = S_WRITE;
        else                            state_d = S_RMW_READ;
      end
      S_LOAD: begin
        rdata_d = (size_q == SIZE_WORD) ? mem_q : lane_ext;
        state_d = S_RESP;
      end
      S_RMW_READ: begin
        mem_data_d = lane_merged;
        state_d    = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      lane_q     <= 1'b0;
      size_q     <= SIZE_BYTE;
      uns_q      <= 1'b0;
      wbyte_q    <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wbyte_q    <= wbyte_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign mem_we     = (state_q == S_WRITE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data   = mem_data_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed-vector bench for dmem_lsu with a simple word-wide memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_size, req_unsigned;
  logic [15:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [15:0] resp_rdata, mem_addr, mem_data, mem_q;
  logic        mem_we;

  logic [15:0] mem [0:65535];

  always #5 clk = ~clk;

  assign mem_q = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data;

  dmem_lsu #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we), .mem_q(mem_q)
  );

  typedef struct {
    logic        we;
    logic        size;
    logic        uns;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        pre_en;
    logic [15:0] pre;
    logic [15:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_wcyc;
    logic [15:0] exp_word;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string tag);
    int  lat, wcyc, nw;
    bit  done;
    logic [15:0] widx;
    widx = {1'b0, v.addr[15:1]};
    if (v.pre_en) mem[widx] <= v.pre;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; resp_ready = 1'b1;
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wcyc = 0; nw = 0; done = 1'b0;
    for (int c = 1; c <= 10 && !done; c++) begin
      @(negedge clk);
      if (mem_we) begin
        nw++;
        if (wcyc == 0) wcyc = c;
      end
      if (resp_valid) begin
        lat  = c;
        done = 1'b1;
        chk({tag, ".rdata"}, 32'(resp_rdata), 32'(v.exp_rdata));
        chk({tag, ".err"}, 32'(resp_err), 32'(v.exp_err));
      end
    end
    if (!done) chk({tag, ".timeout"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, ".latency"}, 32'(lat), 32'(v.exp_lat));
    chk({tag, ".write_cycle"}, 32'(wcyc), 32'(v.exp_wcyc));
    chk({tag, ".write_count"}, 32'(nw), (v.exp_wcyc != 0) ? 32'd1 : 32'd0);
    chk({tag, ".mem_word"}, 32'(mem[widx]), 32'(v.exp_word));
    @(posedge clk);
  endtask

  vec_t tbl [10];
  vec_t v;

  initial begin
    //         we sz u  addr      wdata     pre  preval    rdata     err lat wc word
    tbl[0] = '{1, 1, 0, 16'h0010, 16'hBEEF, 0, 16'h0000, 16'h0000, 0, 2, 1, 16'hBEEF};
    tbl[1] = '{0, 1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 16'hBEEF, 0, 2, 0, 16'hBEEF};
    tbl[2] = '{0, 0, 1, 16'h0011, 16'h0000, 1, 16'h80F1, 16'h0080, 0, 2, 0, 16'h80F1};
    tbl[3] = '{0, 0, 0, 16'h0011, 16'h0000, 1, 16'h80F1, 16'hFF80, 0, 2, 0, 16'h80F1};
    tbl[4] = '{0, 0, 0, 16'h0010, 16'h0000, 1, 16'h80F1, 16'hFFF1, 0, 2, 0, 16'h80F1};
    tbl[5] = '{0, 0, 1, 16'h0010, 16'h0000, 1, 16'h80F1, 16'h00F1, 0, 2, 0, 16'h80F1};
    tbl[6] = '{1, 0, 0, 16'h0011, 16'h00AB, 1, 16'h1234, 16'h0000, 0, 3, 2, 16'hAB34};
    tbl[7] = '{1, 0, 0, 16'h0010, 16'h99CD, 0, 16'h0000, 16'h0000, 0, 3, 2, 16'hABCD};
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    tbl[8] = '{0, 1, 0, 16'h0013, 16'h0000, 1, 16'h5A5A, 16'h0000, 1, 1, 0, 16'h5A5A};
    tbl[9] = '{1, 1, 0, 16'h0015, 16'h7777, 1, 16'h1111, 16'h0000, 1, 1, 0, 16'h1111};
`else
    tbl[8] = '{0, 1, 0, 16'h0013, 16'h0000, 1, 16'h5A5A, 16'h5A5A, 0, 2, 0, 16'h5A5A};
    tbl[9] = '{1, 1, 0, 16'h0015, 16'h7777, 1, 16'h1111, 16'h0000, 0, 2, 1, 16'h7777};
`endif

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    #2;
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.resp_err", 32'(resp_err), 32'd0);
    chk("rst.resp_rdata", 32'(resp_rdata), 32'd0);
    chk("rst.mem_we", 32'(mem_we), 32'd0);
    chk("rst.mem_addr", 32'(mem_addr), 32'd0);
    chk("rst.mem_data", 32'(mem_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 10; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: hold response 5 cycles while a second request waits.
    begin
      bit done;
      int lat;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 1'b1; req_unsigned = 1'b0;
      req_addr = 16'h0010; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_size = 1'b0; req_unsigned = 1'b1; req_addr = 16'h0011;
      done = 1'b0;
      for (int c = 1; c <= 10 && !done; c++) begin
        @(negedge clk);
        done = resp_valid;
      end
      chk("bp.resp_seen", 32'(done), 32'd1);
      for (int i = 0; i < 5; i++) begin
        chk("bp.resp_valid", 32'(resp_valid), 32'd1);
        chk("bp.rdata", 32'(resp_rdata), 32'hABCD);
        chk("bp.req_ready", 32'(req_ready), 32'd0);
        if (i < 4) @(negedge clk);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      chk("bp.idle_req_ready", 32'(req_ready), 32'd1);
      chk("bp.idle_resp_valid", 32'(resp_valid), 32'd0);
      @(posedge clk);
      #1 req_valid = 1'b0;
      done = 1'b0; lat = 0;
      for (int c = 1; c <= 10 && !done; c++) begin
        @(negedge clk);
        if (resp_valid) begin done = 1'b1; lat = c; end
      end
      chk("bp2.latency", 32'(lat), 32'd2);
      chk("bp2.rdata", 32'(resp_rdata), 32'h00AB);
      @(posedge clk);
    end

    // Reset while in RMW_READ of a byte store: memory must be untouched.
    mem[16'h0020] <= 16'h5555;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 1'b0; req_unsigned = 1'b0;
    req_addr = 16'h0041; req_wdata = 16'h0000; resp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 rst = 1'b0;
    #1;
    chk("arst.req_ready", 32'(req_ready), 32'd1);
    chk("arst.resp_valid", 32'(resp_valid), 32'd0);
    chk("arst.mem_we", 32'(mem_we), 32'd0);
    chk("arst.mem_addr", 32'(mem_addr), 32'd0);
    chk("arst.mem_data", 32'(mem_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("arst.mem_word", 32'(mem[16'h0020]), 32'h5555);
    @(posedge clk);
    v = '{0, 1, 0, 16'h0040, 16'h0000, 0, 16'h0000, 16'h5555, 0, 2, 0, 16'h5555};
    run(v, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
